vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares one single-port synchronous video RAM (1-cycle read latency) between the
//  scanout fetch path of the 640x400@70Hz timing generator and a CPU-side bus.
//  Scanout has absolute priority; the CPU gets every cycle scanout leaves free.
//  Sits between the timing generator's 320x200 address and the VRAM block.
// PARAMETERS
//  AW         16  VRAM address width (320x200 = 64000 bytes)
//  DW          8  VRAM data width
//  WBUF_DEPTH  4  posted-write FIFO depth, power of two (VRAM_ARB_WBUF_EN only)
// PORTS
//  iClk       in   1   pixel clock, 25.175MHz
//  iRstN      in   1   asynchronous active-low reset
//  iVidReq    in   1   scanout fetch request, one cycle per new address (at most every 2nd cycle)
//  iVidAddr   in   AW  scanout fetch address, valid with iVidReq
//  oVidData   out  DW  fetched pixel byte
//  oVidValid  out  1   oVidData valid pulse
//  iCpuReq    in   1   CPU request; held with addr/data/we stable until oCpuAck
//  iCpuWe     in   1   1 = write, 0 = read
//  iCpuAddr   in   AW  CPU address
//  iCpuWData  in   DW  CPU write data
//  oCpuAck    out  1   one-cycle completion pulse
//  oCpuRData  out  DW  read data, valid with oCpuAck on reads, held until next read ack
//  oMemAddr   out  AW  registered VRAM address
//  oMemWe     out  1   registered VRAM write enable
//  oMemWData  out  DW  registered VRAM write data
//  iMemRData  in   DW  VRAM read data, valid 1 cycle after address presented
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; in-flight CPU op discarded, no ack; FIFO emptied.
//  - Slot decision each cycle T: iVidReq -> video slot; else CPU slot if FSM grants.
//    Memory outputs registered: slot at T drives oMem* during T+1.
//  - Video: iVidReq at T -> oVidValid/oVidData at T+3 (fixed, never stalls).
//    Video slots always oMemWe=0. Back-to-back iVidReq honoured; CPU simply waits.
//  - CPU FSM: IDLE -> ISSUE (on iCpuReq and no iVidReq) -> write: ACK; read: RWAIT ->
//    RCAP -> ACK -> IDLE. ACK cycle drives oCpuAck=1 and FSM ignores iCpuReq that
//    cycle (requester drops or changes req). iVidReq in IDLE defers grant only.
//  - Read data captured from iMemRData in RCAP into oCpuRData.
//  - CPU latency with no video traffic: write req->ack 2 cycles, read 4 cycles.
//  - In visible region (iVidReq every 2nd cycle) CPU grant delay bounded by 1 cycle.
//  - Address width: no wrap logic; addresses passed through unmodified.
// CONFIGURATION
//  VRAM_ARB_WBUF_EN defined: CPU writes enter a WBUF_DEPTH posted-write FIFO and
//   are acked the cycle after acceptance; FIFO drains into free (non-video) slots in
//   order. Full FIFO: write waits (no ack) until an entry drains. CPU read waits
//   until FIFO empty (read-after-write order preserved). Simultaneous push and pop
//   on full: pop frees slot, push accepted next cycle.
//  Not defined: writes go through FSM directly as above; no FIFO logic present.
// STRUCTURE
//  Package vram_arb_pkg: FSM state enum (IDLE, ISSUE, RWAIT, RCAP, ACK),
//   VID_LAT=3 constant, default AW/DW.
//  Sub-module vram_wbuf: synchronous FIFO {addr,data}, instantiated only under
//   VRAM_ARB_WBUF_EN. Arbitration, FSM and video pipeline stay in this module.
// TESTING
//  1 Reset mid-read (iRstN low during RWAIT) -> no oCpuAck, all outputs 0, FSM IDLE.
//  2 iVidReq addr 0x0000,0x0001 every 2nd cycle, memory preloaded -> oVidValid each
//    at T+3 with correct bytes; no missing or extra pulses.
//  3 No video; CPU write 0x1234<=0xA5 then read 0x1234 -> write ack at +2, read ack
//    at +4, oCpuRData=0xA5.
//  4 Video every 2nd cycle + continuous CPU reads -> video data exact, each CPU grant
//    delayed <=1 cycle, no oMemWe during video slots.
//  5 iVidReq and iCpuReq same cycle, back-to-back video for 8 cycles -> CPU waits
//    all 8, issues on first free cycle.
//  6 VRAM_ARB_WBUF_EN: 5 writes back-to-back during continuous video, then read of
//    the 5th address -> 4 immediate acks, 5th stalls until pop, read returns
//    5th data after FIFO empty.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vram_arb_pkg;

    localparam int AW_DEF  = 16;
    localparam int DW_DEF  = 8;
    localparam int VID_LAT = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RWAIT,
        ST_RCAP,
        ST_ACK
    } cpu_state_e;

endpackage

// File: rtl/vram_wbuf.sv
// Posted-write FIFO holding {addr,data} pairs for the VRAM arbiter.
// Latency: a pushed entry is visible at the head one cycle later.
// Backpressure: push ignored when full, pop ignored when empty; the caller gates on oFull/oEmpty.
module vram_wbuf #(
    parameter int AW    = 16,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          iClk,
    input  logic          iRstN,
    input  logic          iPush,
    input  logic [AW-1:0] iAddr,
    input  logic [DW-1:0] iData,
    input  logic          iPop,
    output logic [AW-1:0] oAddr,
    output logic [DW-1:0] oData,
    output logic          oEmpty,
    output logic          oFull
);
    localparam int PW = $clog2(DEPTH);

    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign oEmpty  = (cnt_q == '0);
    assign oFull   = (cnt_q == (PW+1)'(DEPTH));
    assign do_push = iPush && !oFull;
    assign do_pop  = iPop && !oEmpty;

    assign {oAddr, oData} = mem_q[rd_ptr_q];

    always_ff @(posedge iClk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= {iAddr, iData};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM shared by scanout (absolute priority) and a CPU bus; optional posted writes under VRAM_ARB_WBUF_EN.
// Latency: video req->data 3 cycles fixed; CPU write 2 (1 when posted), CPU read 4 with no video traffic.
// Backpressure: video never stalls; CPU holds iCpuReq until oCpuAck, deferred while video owns the slot or the write FIFO is full.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int WBUF_DEPTH = 4
) (
    input  logic          iClk,
    input  logic          iRstN,
    input  logic          iVidReq,
    input  logic [AW-1:0] iVidAddr,
    output logic [DW-1:0] oVidData,
    output logic          oVidValid,
    input  logic          iCpuReq,
    input  logic          iCpuWe,
    input  logic [AW-1:0] iCpuAddr,
    input  logic [DW-1:0] iCpuWData,
    output logic          oCpuAck,
    output logic [DW-1:0] oCpuRData,
    output logic [AW-1:0] oMemAddr,
    output logic          oMemWe,
    output logic [DW-1:0] oMemWData,
    input  logic [DW-1:0] iMemRData
);
    if ((WBUF_DEPTH < 2) || ((WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("vram_arbiter: WBUF_DEPTH must be a power of two >= 2");
    end

    cpu_state_e         state_q;
    logic               cpu_ack_q;
    logic [DW-1:0]      cpu_rdata_q;
    logic [VID_LAT-2:0] vid_pipe_q;
    logic               vid_valid_q;
    logic [DW-1:0]      vid_data_q;
    logic [DW-1:0]      mem_rdata_q;
    logic [AW-1:0]      mem_addr_q,  mem_addr_d;
    logic               mem_we_q,    mem_we_d;
    logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
    logic               cpu_issue;
    logic               cpu_post;

`ifdef VRAM_ARB_WBUF_EN
    logic          wb_empty;
    logic          wb_full;
    logic          wb_pop;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    // Reads wait for an empty FIFO so they never overtake a posted write.
    assign cpu_issue = (state_q == ST_IDLE) && iCpuReq && !iCpuWe && !iVidReq && wb_empty;
    assign cpu_post  = (state_q == ST_IDLE) && iCpuReq && iCpuWe && !wb_full;
    assign wb_pop    = !iVidReq && !cpu_issue && !wb_empty;

    vram_wbuf #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .iClk   (iClk),
        .iRstN  (iRstN),
        .iPush  (cpu_post),
        .iAddr  (iCpuAddr),
        .iData  (iCpuWData),
        .iPop   (wb_pop),
        .oAddr  (wb_addr),
        .oData  (wb_data),
        .oEmpty (wb_empty),
        .oFull  (wb_full)
    );
`else
    assign cpu_issue = (state_q == ST_IDLE) && iCpuReq && !iVidReq;
    assign cpu_post  = 1'b0;
`endif

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        if (iVidReq) begin
            mem_addr_d = iVidAddr;
        end else if (cpu_issue) begin
            mem_addr_d  = iCpuAddr;
            mem_we_d    = iCpuWe;
            mem_wdata_d = iCpuWData;
        end
`ifdef VRAM_ARB_WBUF_EN
        else if (wb_pop) begin
            mem_addr_d  = wb_addr;
            mem_we_d    = 1'b1;
            mem_wdata_d = wb_data;
        end
`endif
    end

    // iMemRData is valid in RWAIT; staging it lets RCAP commit it and oCpuRData only changes with the ack.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q     <= ST_IDLE;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            cpu_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cpu_issue) begin
                        state_q <= ST_ISSUE;
                    end else if (cpu_post) begin
                        state_q   <= ST_ACK;
                        cpu_ack_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (iCpuWe) begin
                        state_q   <= ST_ACK;
                        cpu_ack_q <= 1'b1;
                    end else begin
                        state_q <= ST_RWAIT;
                    end
                end
                ST_RWAIT: state_q <= ST_RCAP;
                ST_RCAP: begin
                    state_q     <= ST_ACK;
                    cpu_ack_q   <= 1'b1;
                    cpu_rdata_q <= mem_rdata_q;
                end
                ST_ACK:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            mem_rdata_q <= '0;
            vid_pipe_q  <= '0;
            vid_valid_q <= 1'b0;
            vid_data_q  <= '0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rdata_q <= iMemRData;
            vid_pipe_q  <= {vid_pipe_q[VID_LAT-3:0], iVidReq};
            vid_valid_q <= vid_pipe_q[VID_LAT-2];
            if (vid_pipe_q[VID_LAT-2]) begin
                vid_data_q <= iMemRData;
            end
        end
    end

    assign oMemAddr  = mem_addr_q;
    assign oMemWe    = mem_we_q;
    assign oMemWData = mem_wdata_q;
    assign oVidValid = vid_valid_q;
    assign oVidData  = vid_data_q;
    assign oCpuAck   = cpu_ack_q;
    assign oCpuRData = cpu_rdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: drivers queue expected video/CPU responses, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_vram_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;
`ifdef VRAM_ARB_WBUF_EN
    localparam int WR_LAT = 1;
`else
    localparam int WR_LAT = 2;
`endif

    logic          iClk = 1'b0;
    logic          iRstN = 1'b0;
    logic          iVidReq = 1'b0;
    logic [AW-1:0] iVidAddr = '0;
    logic [DW-1:0] oVidData;
    logic          oVidValid;
    logic          iCpuReq = 1'b0;
    logic          iCpuWe = 1'b0;
    logic [AW-1:0] iCpuAddr = '0;
    logic [DW-1:0] iCpuWData = '0;
    logic          oCpuAck;
    logic [DW-1:0] oCpuRData;
    logic [AW-1:0] oMemAddr;
    logic          oMemWe;
    logic [DW-1:0] oMemWData;
    logic [DW-1:0] iMemRData = '0;

    vram_arbiter #(.AW(AW), .DW(DW), .WBUF_DEPTH(4)) dut (
        .iClk      (iClk),
        .iRstN     (iRstN),
        .iVidReq   (iVidReq),
        .iVidAddr  (iVidAddr),
        .oVidData  (oVidData),
        .oVidValid (oVidValid),
        .iCpuReq   (iCpuReq),
        .iCpuWe    (iCpuWe),
        .iCpuAddr  (iCpuAddr),
        .iCpuWData (iCpuWData),
        .oCpuAck   (oCpuAck),
        .oCpuRData (oCpuRData),
        .oMemAddr  (oMemAddr),
        .oMemWe    (oMemWe),
        .oMemWData (oMemWData),
        .iMemRData (iMemRData)
    );

    always #20 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    // Behavioural single-port synchronous VRAM.
    logic [DW-1:0] vram [0:65535];
    always @(posedge iClk) begin
        if (oMemWe) vram[oMemAddr] <= oMemWData;
        iMemRData <= vram[oMemAddr];
    end

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    typedef struct {
        int         at;
        logic [7:0] dat;
        logic       rd;
    } exp_t;

    exp_t vid_q[$];
    exp_t cpu_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
        end
    endfunction

    // Video schedule, so CPU expectations can account for slots video takes.
    int v0 = 0, vn = 0, vstep = 1;

    function automatic bit vid_at(input int c);
        return (vn > 0) && (c >= v0) && (c < v0 + vn * vstep) && (((c - v0) % vstep) == 0);
    endfunction

    function automatic int vid_delay(input int t);
        int k = 0;
        while (k < 64 && vid_at(t + k)) k++;
        return k;
    endfunction

    // Monitor: checks every video/CPU response and that video slots never write.
    logic          vid_prev = 1'b0;
    logic [AW-1:0] vid_prev_addr = '0;
    always @(negedge iClk) begin
        exp_t e;
        if (iRstN) begin
            if (vid_prev) begin
                chk("vid_slot_we", 32'(oMemWe), 32'd0);
                chk("vid_slot_addr", 32'(oMemAddr), 32'(vid_prev_addr));
            end
            if (vid_q.size() > 0 && vid_q[0].at < cyc) begin
                e = vid_q.pop_front();
                chk("vid_missing_at", 32'(cyc), 32'(e.at));
            end
            if (cpu_q.size() > 0 && cpu_q[0].at < cyc) begin
                e = cpu_q.pop_front();
                chk("cpu_missing_ack_at", 32'(cyc), 32'(e.at));
            end
            if (oVidValid) begin
                if (vid_q.size() == 0) begin
                    chk("vid_extra_pulse", 32'd1, 32'd0);
                end else begin
                    e = vid_q.pop_front();
                    chk("vid_cycle", 32'(cyc), 32'(e.at));
                    chk("vid_data", 32'(oVidData), 32'(e.dat));
                end
            end
            if (oCpuAck) begin
                if (cpu_q.size() == 0) begin
                    chk("cpu_extra_ack", 32'd1, 32'd0);
                end else begin
                    e = cpu_q.pop_front();
                    chk("cpu_ack_cycle", 32'(cyc), 32'(e.at));
                    if (e.rd) chk("cpu_rdata", 32'(oCpuRData), 32'(e.dat));
                end
            end
            vid_prev      = iVidReq;
            vid_prev_addr = iVidAddr;
        end else begin
            vid_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic set_sched(input int n, input int step);
        v0 = cyc;
        vn = n;
        vstep = step;
    endtask

    task automatic vid_burst(input logic [AW-1:0] a, input int n, input int step);
        for (int i = 0; i < n; i++) begin
            iVidReq  = 1'b1;
            iVidAddr = a + AW'(i);
            vid_q.push_back('{at: cyc + 3, dat: init_byte(a + AW'(i)), rd: 1'b1});
            tick();
            if (step == 2) begin
                iVidReq = 1'b0;
                tick();
            end
        end
        iVidReq = 1'b0;
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 200; i++) begin
            @(negedge iClk);
            if (oCpuAck) return;
        end
        chk("cpu_ack_timeout", 32'd0, 32'd1);
    endtask

    // Hold the request until the ack, then release it in the following cycle.
    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int lat, input logic [DW-1:0] rexp);
        iCpuReq   = 1'b1;
        iCpuWe    = we;
        iCpuAddr  = a;
        iCpuWData = d;
        cpu_q.push_back('{at: cyc + lat, dat: rexp, rd: !we});
        wait_ack();
        tick();
        iCpuReq = 1'b0;
        iCpuWe  = 1'b0;
    endtask

    task automatic check_outputs_zero(input string nm);
        chk({nm, "_viddata"}, 32'(oVidData), 32'd0);
        chk({nm, "_vidvalid"}, 32'(oVidValid), 32'd0);
        chk({nm, "_cpuack"}, 32'(oCpuAck), 32'd0);
        chk({nm, "_cpurdata"}, 32'(oCpuRData), 32'd0);
        chk({nm, "_memaddr"}, 32'(oMemAddr), 32'd0);
        chk({nm, "_memwe"}, 32'(oMemWe), 32'd0);
        chk({nm, "_memwdata"}, 32'(oMemWData), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) vram[i] = init_byte(16'(i));
        repeat (2) @(negedge iClk);
        check_outputs_zero("reset");
        tick();
        iRstN = 1'b1;
        repeat (2) tick();

        // No video: write then read back.
        cpu_op(1'b1, 16'h1234, 8'hA5, WR_LAT, 8'h00);
        cpu_op(1'b0, 16'h1234, 8'h00, 4, 8'hA5);
        repeat (2) tick();
        chk("vram_1234", 32'(vram[16'h1234]), 32'hA5);

        // Reset asserted while a read sits in RWAIT.
        iCpuReq  = 1'b1;
        iCpuWe   = 1'b0;
        iCpuAddr = 16'h1234;
        repeat (2) tick();
        iRstN = 1'b0;
        @(negedge iClk);
        check_outputs_zero("midread_rst");
        tick();
        iCpuReq = 1'b0;
        tick();
        iRstN = 1'b1;
        repeat (6) tick();
        cpu_op(1'b1, 16'h0300, 8'h77, WR_LAT, 8'h00);
        cpu_op(1'b0, 16'h0300, 8'h00, 4, 8'h77);

        // Two video fetches every 2nd cycle.
        set_sched(2, 2);
        vid_burst(16'h0000, 2, 2);
        repeat (6) tick();

        // Video every 2nd cycle with continuous CPU reads.
        set_sched(10, 2);
        fork
            vid_burst(16'h0010, 10, 2);
            begin
                for (int i = 0; i < 4; i++)
                    cpu_op(1'b0, 16'h0100 + 16'(i), 8'h00, 4 + vid_delay(cyc), init_byte(16'h0100 + 16'(i)));
            end
        join
        repeat (6) tick();

        // Eight back-to-back video fetches collide with a CPU read.
        set_sched(8, 1);
        fork
            vid_burst(16'h0020, 8, 1);
            cpu_op(1'b0, 16'h0200, 8'h00, 4 + vid_delay(cyc), init_byte(16'h0200));
        join
        repeat (6) tick();

`ifdef VRAM_ARB_WBUF_EN
        // Five posted writes under 14 cycles of continuous video, then read the last one.
        set_sched(14, 1);
        fork
            vid_burst(16'h0030, 14, 1);
            begin
                for (int i = 0; i < 4; i++)
                    cpu_op(1'b1, 16'h2000 + 16'(i), 8'h10 + 8'(i), 1, 8'h00);
                cpu_op(1'b1, 16'h2004, 8'h14, 8, 8'h00);
                cpu_op(1'b0, 16'h2004, 8'h00, 6, 8'h14);
            end
        join
        repeat (4) tick();
        for (int i = 0; i < 5; i++)
            chk("wbuf_vram", 32'(vram[16'h2000 + 16'(i)]), 32'h10 + 32'(i));
`endif

        vn = 0;
        repeat (8) tick();
        chk("vid_queue_drained", 32'(vid_q.size()), 32'd0);
        chk("cpu_queue_drained", 32'(cpu_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
